// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Per-bit two-flop synchronizer and debouncer for the board slide switches.
// sw_clean feeds the switch PIO in_port, so software only ever sees levels
// that have been stable for DEBOUNCE_CYCLES consecutive clocks. One-cycle
// rise/fall pulses are produced alongside for edge-driven logic.
//
// Ports
//   clk        : system clock (single domain)
//   reset_n    : synchronous active-low reset, sampled on rising clk
//   sw_raw     : asynchronous, bouncy switch pins
//   sw_clean   : debounced switch levels (registered)
//   sw_rise    : one-cycle pulse per bit when sw_clean goes 0->1 (registered)
//   sw_fall    : one-cycle pulse per bit when sw_clean goes 1->0 (registered)
//   sw_changed : OR of all rise/fall pulses, same cycle as the pulses
//
// Parameters
//   WIDTH           : number of switch bits
//   DEBOUNCE_CYCLES : cycles a new level must persist before acceptance (>= 2)
//   CNT_WIDTH       : counter width, 2**CNT_WIDTH must exceed DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [WIDTH-1:0]     BITS_ZERO = {WIDTH{1'b0}};

  // Synchronizer stages; only sync2_r is used by the debounce logic.
  logic [WIDTH-1:0]     sync1_r;
  logic [WIDTH-1:0]     sync2_r;

  // Per-bit mismatch run counters and their next values.
  logic [CNT_WIDTH-1:0] cnt_r     [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_nxt_s [WIDTH];

  logic [WIDTH-1:0]     accept_s;
  logic [WIDTH-1:0]     clean_nxt_s;
  logic [WIDTH-1:0]     rise_nxt_s;
  logic [WIDTH-1:0]     fall_nxt_s;

  // Per-bit debounce decision: count consecutive mismatches, accept at the last count.
  always_comb begin
    accept_s = BITS_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = CNT_ZERO;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_r[i] == sw_clean[i]) begin
        // Back at the clean level: any partial run is a glitch, forget it.
        accept_s[i]  = 1'b0;
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_LAST) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
        accept_s[i]  = 1'b1;
        cnt_nxt_s[i] = CNT_ZERO;
      end else begin
        accept_s[i]  = 1'b0;
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
    // An accepted bit always flips, so the new level equals sync2_r there.
    clean_nxt_s = sw_clean ^ accept_s;
    rise_nxt_s  = accept_s & sync2_r;
    fall_nxt_s  = accept_s & ~sync2_r;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r    <= BITS_ZERO;
      sync2_r    <= BITS_ZERO;
      sw_clean   <= BITS_ZERO;
      sw_rise    <= BITS_ZERO;
      sw_fall    <= BITS_ZERO;
      sw_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r    <= sw_raw;
      sync2_r    <= sync1_r;
      sw_clean   <= clean_nxt_s;
      sw_rise    <= rise_nxt_s;
      sw_fall    <= fall_nxt_s;
      sw_changed <= |(rise_nxt_s | fall_nxt_s);
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Directed scenarios followed by random switch activity. The reference model
// keeps the full history of driven inputs and decides acceptance with a
// sliding-window rule: a bit flips at edge e when every synchronized sample
// in the last DEBOUNCE_CYCLES edges differs from the clean level and no
// acceptance or reset happened inside that window.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int W    = 6;
  localparam int D    = 4;
  localparam int CW   = 16;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int           edge_n = 0;
  logic [W-1:0] raw_h [MAXE];
  logic         rst_h [MAXE];
  int           last_chg [W];
  logic [W-1:0] m_clean = '0;
  logic [W-1:0] m_rise  = '0;
  logic [W-1:0] m_fall  = '0;
  logic         m_changed = 1'b0;

  switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  // Synchronized value the debouncer compares at edge k: raw from two edges
  // earlier, or zero if either synchronizer stage was reset in between.
  function automatic logic [W-1:0] seen(input int k);
    if (k < 3) return '0;
    else if (rst_h[k-1] || rst_h[k-2]) return '0;
    else return raw_h[k-2];
  endfunction

  task automatic model_edge();
    edge_n++;
    raw_h[edge_n] = sw_raw;
    rst_h[edge_n] = !reset_n;
    m_rise = '0;
    m_fall = '0;
    if (!reset_n) begin
      m_clean = '0;
      for (int i = 0; i < W; i++) last_chg[i] = edge_n;
    end else begin
      for (int i = 0; i < W; i++) begin
        logic         ok;
        logic [W-1:0] s;
        ok = (edge_n - last_chg[i] >= D);
        for (int k = edge_n - D + 1; k <= edge_n; k++) begin
          s = seen(k);
          if (k < 1 || s[i] == m_clean[i]) ok = 1'b0;
        end
        if (ok) begin
          m_clean[i]  = ~m_clean[i];
          last_chg[i] = edge_n;
          if (m_clean[i]) m_rise[i] = 1'b1;
          else            m_fall[i] = 1'b1;
        end
      end
    end
    m_changed = |(m_rise | m_fall);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  // Drive inputs away from the edge, advance one clock, compare on the falling edge.
  task automatic step(input logic [W-1:0] raw, input logic rn);
    sw_raw  = raw;
    reset_n = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_clean",   sw_clean, m_clean);
    check("model_rise",    sw_rise,  m_rise);
    check("model_fall",    sw_fall,  m_fall);
    check("model_changed", {5'b0, sw_changed}, {5'b0, m_changed});
  endtask

  initial begin
    int           pulses;
    int           rise5_cnt;
    int           rise5_at;
    int           fall_cnt;
    logic [W-1:0] r;

    // 1: reset with all switches high, then power-up acceptance
    repeat (3) begin
      step(6'h3F, 1'b0);
      check("s1_rst_clean",   sw_clean, 6'h00);
      check("s1_rst_rise",    sw_rise,  6'h00);
      check("s1_rst_changed", {5'b0, sw_changed}, 6'h00);
    end
    for (int n = 1; n <= 7; n++) begin
      step(6'h3F, 1'b1);
      if (n == 5) check("s1_pre_clean", sw_clean, 6'h00);
      if (n == 6) begin
        check("s1_clean",   sw_clean, 6'h3F);
        check("s1_rise",    sw_rise,  6'h3F);
        check("s1_changed", {5'b0, sw_changed}, 6'h01);
      end
      if (n == 7) check("s1_rise_gone", sw_rise, 6'h00);
    end
    repeat (8) step(6'h00, 1'b1);
    check("s1_back_to_zero", sw_clean, 6'h00);

    // 2: clean step on bit 2
    for (int n = 1; n <= 7; n++) begin
      step(6'h04, 1'b1);
      if (n == 5) check("s2_pre_clean", sw_clean, 6'h00);
      if (n == 6) begin
        check("s2_clean", sw_clean, 6'h04);
        check("s2_rise",  sw_rise,  6'h04);
        check("s2_fall",  sw_fall,  6'h00);
      end
      if (n == 7) check("s2_rise_gone", sw_rise, 6'h00);
    end

    // 3: three-cycle glitch on bit 0 is rejected
    pulses = 0;
    repeat (3) begin
      step(6'h05, 1'b1);
      if (sw_rise != 6'h00 || sw_fall != 6'h00) pulses++;
    end
    repeat (20) begin
      step(6'h04, 1'b1);
      if (sw_rise != 6'h00 || sw_fall != 6'h00) pulses++;
    end
    check("s3_pulses", pulses[W-1:0], 6'h00);
    check("s3_clean",  sw_clean, 6'h04);

    // 4: bounce on bit 5 then settle high
    rise5_cnt = 0;
    rise5_at  = 0;
    fall_cnt  = 0;
    r = 6'h24; step(r, 1'b1);
    r = 6'h04; step(r, 1'b1);
    r = 6'h24; step(r, 1'b1);
    r = 6'h24; step(r, 1'b1);
    r = 6'h04; step(r, 1'b1);
    if (sw_rise[5]) rise5_cnt++;
    for (int n = 1; n <= 8; n++) begin
      step(6'h24, 1'b1);
      if (sw_rise[5]) begin
        rise5_cnt++;
        rise5_at = n;
      end
      if (sw_fall != 6'h00) fall_cnt++;
    end
    check("s4_rise5_count", rise5_cnt[W-1:0], 6'd1);
    check("s4_rise5_edge",  rise5_at[W-1:0],  6'd6);
    check("s4_fall_count",  fall_cnt[W-1:0],  6'd0);

    // 5: simultaneous falls and rises
    repeat (8) step(6'h03, 1'b1);
    check("s5_start_clean", sw_clean, 6'h03);
    for (int n = 1; n <= 7; n++) begin
      step(6'h30, 1'b1);
      if (n == 5) check("s5_pre_changed", {5'b0, sw_changed}, 6'h00);
      if (n == 6) begin
        check("s5_fall",    sw_fall,  6'h03);
        check("s5_rise",    sw_rise,  6'h30);
        check("s5_changed", {5'b0, sw_changed}, 6'h01);
        check("s5_clean",   sw_clean, 6'h30);
      end
      if (n == 7) check("s5_changed_gone", {5'b0, sw_changed}, 6'h00);
    end

    // 6: reset in the middle of a pending change on bit 1
    repeat (3) begin
      step(6'h32, 1'b1);
      check("s6_no_early_rise", sw_rise, 6'h00);
    end
    step(6'h32, 1'b0);
    check("s6_rst_clean", sw_clean, 6'h00);
    for (int n = 1; n <= 7; n++) begin
      step(6'h32, 1'b1);
      if (n == 5) check("s6_pre_clean", sw_clean, 6'h00);
      if (n == 6) begin
        check("s6_clean", sw_clean, 6'h32);
        check("s6_rise",  sw_rise,  6'h32);
      end
    end

    // Random switch activity with occasional resets
    r = 6'h32;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
      end
      step(r, ($urandom_range(0, 199) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Per-bit synchronizer and debouncer for the DE0 slide switches. Sits directly upstream of the Avalon switch PIO: raw board pins enter here, and `sw_clean` drives the PIO's 6-bit `in_port`, so software reads only settled values. Also emits one-cycle rise/fall pulses per bit for edge-driven logic. Adds no bus interface.

## Interface

- Parameters
  - `WIDTH`, 6: number of switch bits.
  - `DEBOUNCE_CYCLES`, 50000: consecutive cycles a new level must persist before acceptance (1 ms at 50 MHz). Legal range is ≥ 2.
  - `CNT_WIDTH`, 16: counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- Ports
  - `clk`, in, 1: system clock. The block uses one clock and has no other clock domain.
  - `reset_n`, in, 1: synchronous, active-low reset. It is sampled only on the rising edge of `clk`.
  - `sw_raw`, in, WIDTH: asynchronous, bouncy switch pins.
  - `sw_clean`, out, WIDTH: debounced level. Connects to the PIO `in_port`.
  - `sw_rise`, out, WIDTH: one-cycle pulse per bit when `sw_clean` goes 0→1.
  - `sw_fall`, out, WIDTH: one-cycle pulse per bit when `sw_clean` goes 1→0.
  - `sw_changed`, out, 1: OR-reduction of `sw_rise | sw_fall`, registered in the same cycle as the pulses.

## Operation

- Each bit is processed independently and identically. There is no cross-bit interaction.
- Synchronizer: two flops per bit. `sync1` samples `sw_raw` and `sync2` samples `sync1`. Only `sync2` feeds the debounce logic.
- Per-bit counter `cnt[i]`, CNT_WIDTH bits. At each clock edge:
  - If `sync2[i] == sw_clean[i]`: `cnt[i]` is set to 0 and there are no pulses.
  - Else, if `cnt[i] == DEBOUNCE_CYCLES-1`:
    - `sw_clean[i]` takes `sync2[i]`.
    - `cnt[i]` is set to 0.
    - `sw_rise[i]` or `sw_fall[i]` is set to 1 for that cycle, according to the new value.
  - Else: `cnt[i]` is incremented by 1.
- `sw_rise` and `sw_fall` are cleared on every edge where no acceptance occurs. They are never held.
- Glitch rejection: any return to the clean level before the count completes clears the counter. A mismatch run shorter than DEBOUNCE_CYCLES therefore never reaches the output.
- The counter cannot wrap. It clears before exceeding DEBOUNCE_CYCLES-1.
- Reset (`reset_n` = 0 at a clock edge), applied to all bits regardless of in-progress counts:
  - `sync1`, `sync2`, `sw_clean`, and `cnt` are cleared to 0.
  - `sw_rise`, `sw_fall`, and `sw_changed` are cleared to 0.
- Power-up/reset behaviour: a switch held high through reset is accepted as 1 after the full debounce latency. This produces one `sw_rise` pulse. That behaviour is intended and required.

## Timing

- All outputs are registered, with no combinational path from input to output.
- Reset values: `sw_clean` = 0, `sw_rise` = 0, `sw_fall` = 0, `sw_changed` = 0.
- Latency: `sw_raw[i]` changes before edge E1 and then stays stable.
  - `sync2` reflects the new value after E2.
  - `sw_clean[i]` and the pulse update at edge E(DEBOUNCE_CYCLES+2).
  - With DEBOUNCE_CYCLES = 4, the output updates at the 6th edge.
- Pulse width is exactly one `clk` cycle. It coincides with the first cycle of the new `sw_clean` value.
- The downstream PIO registers `in_port` one more cycle later. Software-visible latency is therefore DEBOUNCE_CYCLES+3 cycles.
- Simultaneous acceptance on several bits:
  - Multiple `sw_rise`/`sw_fall` bits may be set in the same cycle.
  - `sw_changed` is a single pulse in that cycle.
- A bit accepted in cycle k may start a new mismatch count in cycle k+1. Minimum spacing between its accepted edges is DEBOUNCE_CYCLES cycles.
- Reset mid-count discards the pending change. After `reset_n` returns to 1, counting restarts from 0 with the full latency.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and WIDTH = 6.

1. Reset: hold `reset_n` = 0 for 3 edges with `sw_raw` = 6'h3F. Required: all outputs are 0 during reset. After release, `sw_clean` = 6'h3F at the 6th edge, `sw_rise` = 6'h3F for 1 cycle, and `sw_changed` pulses once.
2. Clean step: with `sw_clean` = 0, set `sw_raw[2]` = 1 steadily. Required: `sw_clean` = 6'h04 at edge 6, `sw_rise` = 6'h04 for exactly 1 cycle, and `sw_fall` stays 0.
3. Glitch rejection: pulse `sw_raw[0]` high for 3 cycles, then low. Required: `sw_clean` stays 0, with no pulses over 20 cycles.
4. Bounce: toggle `sw_raw[5]` as 1,0,1,1,0, then hold 1. Required: exactly one `sw_rise[5]`, at edge 6 after the final 0→1, with no `sw_fall`.
5. Fall and simultaneity: from `sw_clean` = 6'h03, drive `sw_raw` = 6'h30 in one cycle. Required: `sw_fall` = 6'h03 and `sw_rise` = 6'h30 in the same cycle, with a single `sw_changed` pulse.
6. Reset mid-count: `sw_raw[1]` rises, and `reset_n` = 0 at edge 4 for 1 cycle. Required: no pulse before reset, and `sw_clean[1]` = 1 at the 6th edge after reset release.
